// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace capture block: controller state
// encoding, record layout and a record-packing helper.
package trace_pkg;

  // Width of one trace record.
  localparam int REC_W = 56;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Record field offsets (LSB of each field); bits [1:0] are spare and always zero.
  localparam int KIND_BIT = 55;
  localparam int ADDR_LSB = 39;
  localparam int OP_LSB   = 34;
  localparam int VAL_LSB  = 18;
  localparam int TOS_LSB  = 2;

  typedef enum logic {
    KIND_ISSUE = 1'b0,
    KIND_MEMWR = 1'b1
  } rec_kind_e;

  // Assemble one record from its fields, leaving the spare bits at zero.
  function automatic logic [REC_W-1:0] make_rec(
    input rec_kind_e   kind,
    input logic [15:0] addr,
    input logic [4:0]  opcode,
    input logic [15:0] value,
    input logic [15:0] tos
  );
    logic [REC_W-1:0] r;
    r                  = '0;
    r[KIND_BIT]        = kind;
    r[ADDR_LSB +: 16]  = addr;
    r[OP_LSB +: 5]     = opcode;
    r[VAL_LSB +: 16]   = value;
    r[TOS_LSB +: 16]   = tos;
    return r;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace buffer storage: one write port, one registered read port.
// Array contents are never reset; only the read register is, so the
// record output reads as zero straight out of reset.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = REC_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (reset)   rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_capture.sv
// Instruction trace capture: records issued instructions into a circular
// buffer once armed, keeps POST_COUNT more after the trigger address is
// seen, then streams the buffer out oldest-first over a valid/ready port.
// Optional macro TRACE_MEMWRITE_EN also captures data-memory writes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no session; waiting for arm
// ARMED    | capturing every issue, watching for trigger_ip
// POST     | trigger seen; capturing post_cnt more issues
// DRAIN    | capture frozen; presenting records, counting drops
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int POST_COUNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [15:0]      trigger_ip,
  input  logic             issue_valid,
  input  logic [15:0]      issue_ip,
  input  logic [4:0]       issue_opcode,
  input  logic [15:0]      issue_param,
  input  logic [15:0]      issue_tos,
  input  logic             mem_write_enable,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_write_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic             busy,
  output logic [7:0]       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_COUNT);

  logic [1:0]       state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [AW-1:0]    post_cnt;
  logic             capturing;
  logic             in_drain;
  logic             ev_mem;
  logic             store;
  logic             hit;
  logic             rd_en;
  logic             xfer;
  logic [REC_W-1:0] wr_rec;
  logic [1:0]       drop_inc;
  logic [8:0]       drop_sum;

  assign capturing = (state == ST_ARMED) || (state == ST_POST);
  assign in_drain  = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);

`ifdef TRACE_MEMWRITE_EN
  assign ev_mem = mem_write_enable;
`else
  logic unused_mem;
  assign ev_mem     = 1'b0;
  assign unused_mem = ^{mem_write_enable, mem_addr, mem_write_value};
`endif

  assign store = capturing && (issue_valid || ev_mem);
  assign hit   = (state == ST_ARMED) && issue_valid && (issue_ip == trigger_ip);
  assign xfer  = out_valid && out_ready;

  // Load the next record into the output register whenever the output slot
  // is empty or being consumed this cycle; this gives one record per cycle
  // under a steady out_ready and holds out_data while stalled.
  assign rd_en = in_drain && (count != '0) && (!out_valid || out_ready);

  // Record to store: an issue always wins over a coincident memory write.
  always_comb begin
    wr_rec = make_rec(KIND_ISSUE, issue_ip, issue_opcode, issue_param, issue_tos);
`ifdef TRACE_MEMWRITE_EN
    if (!issue_valid) wr_rec = make_rec(KIND_MEMWR, mem_addr, 5'd0, mem_write_value, issue_tos);
`endif
  end

  // Lost events: everything during DRAIN, plus a memwrite collision while capturing.
  always_comb begin
    drop_inc = 2'd0;
    if (in_drain)
      drop_inc = {1'b0, issue_valid} + {1'b0, ev_mem};
    else if (capturing && issue_valid && ev_mem)
      drop_inc = 2'd1;
    drop_sum = {1'b0, dropped} + {7'd0, drop_inc};
  end

  // Session FSM, buffer pointers, occupancy and output valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      out_valid <= 1'b0;
      dropped   <= '0;
    end else begin
      dropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      // Full buffer: the write lands on the oldest slot, so the read side
      // advances with it and the occupancy stays at DEPTH.
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == FULL) rd_ptr <= rd_ptr + 1'b1;
        else               count  <= count + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (arm) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (hit) begin
            post_cnt <= POST_INIT;
            state    <= (POST_COUNT == 0) ? ST_DRAIN : ST_POST;
          end
        end
        ST_POST: begin
          if (issue_valid) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rd_en) begin
            rd_ptr    <= rd_ptr + 1'b1;
            count     <= count - 1'b1;
            out_valid <= 1'b1;
          end else if (xfer || !out_valid) begin
            // Buffer empty and nothing left pending in the output register.
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (store),
    .wr_addr (wr_ptr),
    .wr_data (wr_rec),
    .re      (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule
